// File: rtl/isa_pkg.sv
// Shared ISA encodings for the multicycle datapath: opcodes, op_ext codes,
// condition codes, PSR bit positions and the fetch FSM encoding.
package isa_pkg;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_OPEXT  = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_CMP   = 4'b1011;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational Bcond/Jcond evaluator: condition code against PSR {C,L,F,Z,N}.
module cond_check
    import isa_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       branch
);

    logic c, l, f, z, n;
    assign c = psr[PSR_C];
    assign l = psr[PSR_L];
    assign f = psr[PSR_F];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];

    always_comb begin
        branch = 1'b0;
        case (cond)
            CC_EQ: branch = z;
            CC_NE: branch = !z;
            CC_CS: branch = c;
            CC_CC: branch = !c;
            CC_HI: branch = l;
            CC_LS: branch = !l;
            CC_GT: branch = n;
            CC_LE: branch = !n;
            CC_FS: branch = f;
            CC_FC: branch = !f;
            CC_LO: branch = !l && !z;
            CC_HS: branch = l || z;
            CC_LT: branch = !n && !z;
            CC_GE: branch = n || z;
            CC_UC: branch = 1'b1;
            default: branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// Instruction fetch/capture, field split, PSR ownership and branch condition
// evaluation for the multicycle controller.
module instr_decode
    import isa_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MEM_LATENCY = 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_en,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [4:0]       flags_in,
    input  logic [4:0]       flag_mask,
    input  logic             psr_wr,
    output logic             ir_valid,
    output logic             fetch_busy,
    output logic             fetch_overrun,
    output logic [WIDTH-1:0] instr,
    output logic [3:0]       op,
    output logic [3:0]       rdest,
    output logic [3:0]       cond,
    output logic [3:0]       op_ext,
    output logic [3:0]       rsrc,
    output logic [WIDTH-1:0] imm_sext,
    output logic [WIDTH-1:0] imm_zext,
    output logic [4:0]       psr,
    output logic             branch
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

    fetch_state_e     state, state_nxt;
    logic [1:0]       lat_cnt, lat_nxt;
    logic [WIDTH-1:0] ir;
    logic             ir_load, vld_nxt, ovr_set;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= F_IDLE;
            lat_cnt       <= 2'd0;
            ir            <= '0;
            ir_valid      <= 1'b0;
            fetch_overrun <= 1'b0;
            psr           <= 5'd0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            ir_valid <= vld_nxt;
            if (ir_load) ir <= mem_rdata;
            if (ovr_set) fetch_overrun <= 1'b1;
            if (psr_wr)  psr <= (psr & ~flag_mask) | (flags_in & flag_mask);
        end
    end

    // A request arriving mid-fetch is dropped; only the sticky overrun flag records it.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        ir_load   = 1'b0;
        vld_nxt   = ir_valid;
        ovr_set   = 1'b0;
        case (state)
            F_IDLE, F_HOLD: begin
                if (fetch_en) begin
                    state_nxt = F_WAIT;
                    lat_nxt   = LAT_INIT;
                    vld_nxt   = 1'b0;
                end
            end
            F_WAIT: begin
                ovr_set = fetch_en;
                if (lat_cnt == 2'd0) begin
                    ir_load   = 1'b1;
                    state_nxt = F_HOLD;
                    vld_nxt   = 1'b1;
                end else begin
                    lat_nxt = lat_cnt - 2'd1;
                end
            end
            default: state_nxt = F_IDLE;
        endcase
    end

    assign fetch_busy = (state == F_WAIT);

    assign instr    = ir;
    assign op       = ir[15:12];
    assign rdest    = ir[11:8];
    assign cond     = ir[11:8];
    assign op_ext   = ir[7:4];
    assign rsrc     = ir[3:0];
    assign imm_sext = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign imm_zext = {{(WIDTH-8){1'b0}}, ir[7:0]};

    cond_check u_cond_check (
        .cond   (ir[11:8]),
        .psr    (psr),
        .branch (branch)
    );

endmodule
